// File: rtl/msg_parser.sv
// msg_parser: collects terminator-delimited byte messages and decodes IFM/PBM commands into sticky flags
module msg_parser #(
   parameter int         MAX_LEN    = 12,
   parameter logic [7:0] TERM_CHAR  = 8'h23,
   parameter int         NUM_BLOCKS = 4,
   parameter int         BLOCK_W    = $clog2(NUM_BLOCKS)
) (
   input  logic               clk_50M,
   input  logic               rst_n,
   input  logic [7:0]         rx_msg,
   input  logic               rx_complete,
   input  logic               flag_clear,
   output logic               EU_fault_flag,
   output logic               CU_fault_flag,
   output logic               RU_fault_flag,
   output logic               pick_block_flag,
   output logic               switch_key,
   output logic [BLOCK_W-1:0] block_location,
   output logic               msg_valid,
   output logic               msg_error
);
   localparam int IW = $clog2(MAX_LEN + 1);
   typedef enum logic [1:0] {COLLECT, DECODE, DISCARD} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] idx, idx_nxt, len, len_nxt, waddr;
   logic [7:0] mem [0:MAX_LEN-1];
   logic run, store, is_term, dec, ifm_hit, pbm_hit, hit;
   assign is_term = rx_msg == TERM_CHAR;
   assign dec = state == DECODE;
   assign waddr = dec ? '0 : idx;
   assign ifm_hit = len >= IW'(5) && {mem[0], mem[1], mem[2], mem[3]} == "IFM-" &&
                    (mem[4] == 8'h45 || mem[4] == 8'h43 || mem[4] == 8'h52);
   assign pbm_hit = len >= IW'(9) &&
                    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]} == "PBM-SU-B" &&
                    mem[8] >= 8'h31 && mem[8] <= 8'(8'h30 + NUM_BLOCKS);
   assign hit = ifm_hit || pbm_hit;
   // Reset release synchroniser: logic runs from the second edge after release
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end
   // Next-state logic; an overflowed message passes through DECODE with length 0 so it is rejected
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      len_nxt   = len;
      store     = 1'b0;
      case (state)
         COLLECT: if (rx_complete) begin
            if (is_term) begin
               if (idx != '0) begin
                  len_nxt   = idx;
                  state_nxt = DECODE;
               end
            end else if (idx == IW'(MAX_LEN)) state_nxt = DISCARD;
            else begin
               store   = 1'b1;
               idx_nxt = idx + IW'(1);
            end
         end
         DECODE: begin
            state_nxt = COLLECT;
            idx_nxt   = '0;
            if (rx_complete && !is_term) begin
               store   = 1'b1;
               idx_nxt = IW'(1);
            end
         end
         DISCARD: if (rx_complete && is_term) begin
            len_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = DECODE;
         end
         default: state_nxt = COLLECT;
      endcase
   end
   // State, index and latched length registers
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
         idx   <= '0;
         len   <= '0;
      end else if (run) begin
         state <= state_nxt;
         idx   <= idx_nxt;
         len   <= len_nxt;
      end
   end
   // Payload buffer; stale contents are harmless because decode is qualified by len
   always_ff @(posedge clk_50M) begin
      if (run && store) mem[waddr] <= rx_msg;
   end
   // Sticky flags, block index and result pulses; a match beats a simultaneous flag_clear
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         EU_fault_flag   <= 1'b0;
         CU_fault_flag   <= 1'b0;
         RU_fault_flag   <= 1'b0;
         pick_block_flag <= 1'b0;
         switch_key      <= 1'b0;
         block_location  <= '0;
         msg_valid       <= 1'b0;
         msg_error       <= 1'b0;
      end else if (run) begin
         EU_fault_flag   <= (dec && ifm_hit && mem[4] == 8'h45) || (EU_fault_flag && !flag_clear);
         CU_fault_flag   <= (dec && ifm_hit && mem[4] == 8'h43) || (CU_fault_flag && !flag_clear);
         RU_fault_flag   <= (dec && ifm_hit && mem[4] == 8'h52) || (RU_fault_flag && !flag_clear);
         switch_key      <= (dec && ifm_hit) || (switch_key && !flag_clear);
         pick_block_flag <= (dec && pbm_hit) || (pick_block_flag && !flag_clear);
         block_location  <= (dec && pbm_hit) ? BLOCK_W'(mem[8] - 8'h31) : block_location;
         msg_valid       <= dec && hit;
         msg_error       <= dec && !hit;
      end
   end
endmodule

// File: tb/tb_msg_parser.sv
// tb_msg_parser: scoreboard bench for msg_parser with directed messages
module tb_msg_parser;
   logic clk_50M = 1'b0, rst_n = 1'b0, rx_complete = 1'b0, flag_clear = 1'b0;
   logic [7:0] rx_msg = '0;
   logic EU_fault_flag, CU_fault_flag, RU_fault_flag, pick_block_flag, switch_key, msg_valid, msg_error;
   logic [1:0] block_location;
   int n_checks = 0, n_fail = 0, cyc = 0;
   logic [8:0] exp_q [$];
   int due_q [$];
   logic prev_pulse = 1'b0;

   msg_parser dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .rx_msg(rx_msg), .rx_complete(rx_complete),
      .flag_clear(flag_clear), .EU_fault_flag(EU_fault_flag), .CU_fault_flag(CU_fault_flag),
      .RU_fault_flag(RU_fault_flag), .pick_block_flag(pick_block_flag), .switch_key(switch_key),
      .block_location(block_location), .msg_valid(msg_valid), .msg_error(msg_error)
   );

   always #10 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   function automatic logic [8:0] outs();
      return {msg_valid, msg_error, EU_fault_flag, CU_fault_flag, RU_fault_flag,
              pick_block_flag, switch_key, block_location};
   endfunction

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b (v,e,eu,cu,ru,pk,sk,bl)", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_msg = b;
      rx_complete = 1'b1;
      @(posedge clk_50M);
      #1 rx_complete = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic expect_msg(input logic v, e, eu, cu, ru, pk, sk, input logic [1:0] bl);
      exp_q.push_back({v, e, eu, cu, ru, pk, sk, bl});
      due_q.push_back(cyc + 1);
   endtask

   // Monitor: every result pulse must match the oldest expectation, on the expected cycle
   always @(negedge clk_50M) begin
      logic pulse;
      logic [8:0] e;
      int d;
      pulse = msg_valid | msg_error;
      if (rst_n && pulse) begin
         n_checks++;
         if (prev_pulse) begin
            n_fail++;
            $display("FAIL pulse_width got=2+ cycles exp=1 cycle at cyc %0d", cyc);
         end
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse got=%b exp=no pulse at cyc %0d", outs(), cyc);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check("msg_result", outs(), e);
            n_checks++;
            if (cyc != d) begin
               n_fail++;
               $display("FAIL latency got=cyc %0d exp=cyc %0d", cyc, d);
            end
         end
      end
      prev_pulse = rst_n && pulse;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #15 check("reset_state", outs(), 9'b0);
      @(negedge clk_50M) rst_n = 1'b1;
      repeat (3) @(posedge clk_50M);
      #1;
      send_str("IFM-C-#");             expect_msg(1,0, 0,1,0,0,1, 2'd0);
      send_str("PBM-SU-B3-#");         expect_msg(1,0, 0,1,0,1,1, 2'd2);
      repeat (3) @(posedge clk_50M);
      #1 flag_clear = 1'b1;
      @(posedge clk_50M);
      #1 flag_clear = 1'b0;
      check("flag_clear", outs(), {2'b00, 5'b00000, 2'd2});
      send_str("AAAAAAAAAAAAA#");      expect_msg(0,1, 0,0,0,0,0, 2'd2);
      send_str("IFM-E-#");             expect_msg(1,0, 1,0,0,0,1, 2'd2);
      send_str("PBM-SU-B7-#");         expect_msg(0,1, 1,0,0,0,1, 2'd2);
      send_str("#");
      repeat (4) @(posedge clk_50M);
      #1;
      send_str("IFM-R");
      #3 rst_n = 1'b0;
      #2 check("async_reset", outs(), 9'b0);
      @(negedge clk_50M);
      @(negedge clk_50M) rst_n = 1'b1;
      repeat (3) @(posedge clk_50M);
      #1;
      send_str("-#");                  expect_msg(0,1, 0,0,0,0,0, 2'd0);
      send_str("IFM-E-#");             expect_msg(1,0, 1,0,0,0,1, 2'd0);
      send_str("IFM-R-#");             expect_msg(1,0, 1,0,1,0,1, 2'd0);
      repeat (3) @(posedge clk_50M);
      #1;
      send_str("IFM-C-#");
      flag_clear = 1'b1;               expect_msg(1,0, 0,1,0,0,1, 2'd0);
      @(posedge clk_50M);
      #1 flag_clear = 1'b0;
      send_str("PBM-SU-B4xyz#");       expect_msg(1,0, 0,1,0,1,1, 2'd3);
      send_str("PBM-SU-B1#");          expect_msg(1,0, 0,1,0,1,1, 2'd0);
      send_str("IFM-#");               expect_msg(0,1, 0,1,0,1,1, 2'd0);
      send_str("IFM-Rxx#");            expect_msg(1,0, 0,1,1,1,1, 2'd0);
      send_str("IF#");                 expect_msg(0,1, 0,1,1,1,1, 2'd0);
      send_str("PBM-SU-B0#");          expect_msg(0,1, 0,1,1,1,1, 2'd0);
      repeat (5) @(posedge clk_50M);
      #1;
      check("final_flags", outs(), {2'b00, 5'b01111, 2'd0});
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_pulses got=%0d pending exp=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
